// File: rtl/align_shifter_pipe.sv
// align_shifter_pipe
//   Pipelined alignment right-shifter for the FP add/sub datapath. The
//   significand is extended with two zero bits, {significand_i, 2'b00}, and
//   shifted right by diff_i. The result is the upper SIG_W bits plus
//   {guard, round, sticky}. Sticky is exact for any shift amount. The shift
//   is a logarithmic shifter whose levels are spread over STAGES register
//   stages. Valid/ready flow control is provided, with bubble collapsing.
//
//   Parameters: SIG_W (significand width, >=4), DIFF_W (shift-amount width),
//               STAGES (1..4, latency in cycles), TAG_W (sideband tag width).
//   Ports:
//     clk_i, rst_i               clock, async active-high reset
//     in_valid_i / in_ready_o    input handshake
//     significand_i, diff_i      operand and right-shift amount
//     tag_i                      sideband tag, returned unchanged
//     out_valid_o / out_ready_i  output handshake
//     significand_o              aligned significand
//     guard_o                    {guard, round, sticky}
//     tag_o                      tag of the current result
//     zero_o                     only with ALIGN_ZERO_FLAG_EN: input was zero
//
//   Optional feature macro: ALIGN_ZERO_FLAG_EN (adds zero_o).
module align_shifter_pipe #(
  parameter int SIG_W  = 24,
  parameter int DIFF_W = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SIG_W-1:0]  significand_i,
  input  logic [DIFF_W-1:0] diff_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SIG_W-1:0]  significand_o,
  output logic [2:0]        guard_o,
  output logic [TAG_W-1:0]  tag_o
`ifdef ALIGN_ZERO_FLAG_EN
  ,
  output logic              zero_o
`endif
);

  localparam int unsigned W   = SIG_W + 2;
  localparam int unsigned LVL = $clog2(W + 1);
  localparam int unsigned LPS = (LVL + STAGES - 1) / STAGES;
  localparam int unsigned CW  = ((DIFF_W > LVL) ? DIFF_W : LVL) + 1;

  typedef struct packed {
    logic [W-1:0]     data;
    logic             sticky;
    logic [LVL-1:0]   amt;
    logic [TAG_W-1:0] tag;
`ifdef ALIGN_ZERO_FLAG_EN
    logic             zero;
`endif
  } stage_t;

  function automatic logic [W-1:0] low_mask(int unsigned n);
    logic [W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < W; i++) m[i] = (i < n);
    return m;
  endfunction

  // Apply the shifter levels [lo, lo+LPS). Bits falling off the bottom of
  // the W-bit window are folded into sticky, so nothing is ever lost.
  function automatic stage_t apply_levels(stage_t x, int unsigned lo);
    stage_t r;
    r = x;
    for (int unsigned k = 0; k < LVL; k++) begin
      if (k >= lo && k < lo + LPS && r.amt[k]) begin
        r.sticky = r.sticky | (|(r.data & low_mask(1 << k)));
        r.data   = r.data >> (1 << k);
      end
    end
    return r;
  endfunction

  logic [CW-1:0]     diff_ext;
  logic [LVL-1:0]    amt_in;
  stage_t            src0;
  stage_t            nxt [STAGES];
  stage_t            q   [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES:0]   take;

  // Any shift of W or more moves every bit below the round position; clamp
  // to W so the shifter needs only enough levels to cover 0..W.
  always_comb begin
    diff_ext = CW'(diff_i);
    amt_in   = (diff_ext < CW'(W)) ? LVL'(diff_ext) : LVL'(W);
  end

  always_comb begin
    src0      = '0;
    src0.data = {significand_i, 2'b00};
    src0.amt  = amt_in;
    src0.tag  = tag_i;
`ifdef ALIGN_ZERO_FLAG_EN
    src0.zero = ~|significand_i;
`endif
    nxt[0] = apply_levels(src0, 0);
    for (int unsigned s = 1; s < STAGES; s++) begin
      nxt[s] = apply_levels(q[s-1], s * LPS);
    end
  end

  // take[s]: stage s can accept this cycle; take[STAGES] is the consumer.
  always_comb begin
    take         = '0;
    adv          = '0;
    load         = '0;
    take[STAGES] = out_ready_i;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[STAGES-1-i]  = v_q[STAGES-1-i] && take[STAGES-i];
      take[STAGES-1-i] = !v_q[STAGES-1-i] || adv[STAGES-1-i];
    end
    load[0] = in_valid_i && take[0];
    for (int unsigned s = 1; s < STAGES; s++) begin
      load[s] = adv[s-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) q[s] <= '0;
    end else begin
      v_q <= load | (v_q & ~adv);
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (load[s]) q[s] <= nxt[s];
      end
    end
  end

  assign in_ready_o    = take[0];
  assign out_valid_o   = v_q[STAGES-1];
  assign significand_o = q[STAGES-1].data[W-1:2];
  assign guard_o       = {q[STAGES-1].data[1:0], q[STAGES-1].sticky};
  assign tag_o         = q[STAGES-1].tag;
`ifdef ALIGN_ZERO_FLAG_EN
  assign zero_o        = q[STAGES-1].zero;
`endif

endmodule

// File: tb/tb_align_shifter_pipe.sv
// tb_align_shifter_pipe
//   Directed bench for align_shifter_pipe (SIG_W=24, DIFF_W=8, STAGES=2,
//   TAG_W=4). Inputs are driven on the falling edge; registered outputs are
//   sampled on the falling edge, combinational in_ready_o 1ns after driving.
//   Optional feature macro: ALIGN_ZERO_FLAG_EN (also checks zero_o).
module tb_align_shifter_pipe;

  localparam int SIG_W  = 24;
  localparam int DIFF_W = 8;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SIG_W-1:0]  sig_in;
  logic [DIFF_W-1:0] diff;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [SIG_W-1:0]  sig_out;
  logic [2:0]        guard;
  logic [TAG_W-1:0]  tag_out;
`ifdef ALIGN_ZERO_FLAG_EN
  logic              zero;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  align_shifter_pipe #(
    .SIG_W (SIG_W),
    .DIFF_W(DIFF_W),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .significand_i(sig_in),
    .diff_i       (diff),
    .tag_i        (tag_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .significand_o(sig_out),
    .guard_o      (guard),
    .tag_o        (tag_out)
`ifdef ALIGN_ZERO_FLAG_EN
    ,
    .zero_o       (zero)
`endif
  );

  // Reference: plain wide shift, sticky = OR of the bits that fall off.
  function automatic logic [26:0] model_align(logic [23:0] s, logic [7:0] d);
    logic [25:0] x, y, m;
    logic st;
    x = {s, 2'b00};
    if (d >= 8'd26) begin
      y  = '0;
      st = |s;
    end else begin
      y  = x >> d;
      m  = (26'd1 << d) - 26'd1;
      st = |(x & m);
    end
    return {y, st};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sig_in = '0; diff = '0; tag_in = '0;
    #3;
    checks++;
    if ({out_valid, sig_out, guard, tag_out} !== '0)
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, sig_out, guard, tag_out});
`ifdef ALIGN_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
`endif
    if ({out_valid, sig_out, guard, tag_out} !== '0) errors++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [23:0] v_sig [13] = '{24'hC00001, 24'h800001, 24'hABCDEF, 24'h800001, 24'h000000,
                                24'h800001, 24'h800000, 24'h000003, 24'h000003, 24'h123456,
                                24'hFFFFFF, 24'h00C000, 24'h800000};
    logic [7:0]  v_dif [13] = '{8'd1, 8'd24, 8'd0, 8'd30, 8'd255, 8'd25, 8'd26, 8'd2, 8'd3,
                                8'd8, 8'd24, 8'd16, 8'd23};
    logic [23:0] e_sig [13] = '{24'h600000, 24'h000000, 24'hABCDEF, 24'h000000, 24'h000000,
                                24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h001234,
                                24'h000000, 24'h000000, 24'h000001};
    logic [2:0]  e_grd [13] = '{3'b100, 3'b101, 3'b000, 3'b001, 3'b000, 3'b011, 3'b001,
                                3'b110, 3'b011, 3'b011, 3'b111, 3'b110, 3'b000};
    for (int unsigned i = 0; i < 13; i++) begin
      @(negedge clk);
      in_valid = 1'b1; sig_in = v_sig[i]; diff = v_dif[i]; tag_in = 4'(i); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_latency1: out_valid got %b expected 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, sig_out, guard, tag_out} !== {1'b1, e_sig[i], e_grd[i], 4'(i)}) begin
        errors++;
        $display("FAIL dir%0d_result: got v=%b sig=%h g=%b tag=%h expected v=1 sig=%h g=%b tag=%h",
                 i, out_valid, sig_out, guard, tag_out, e_sig[i], e_grd[i], 4'(i));
      end
`ifdef ALIGN_ZERO_FLAG_EN
      checks++;
      if (zero !== (e_sig[i] == 0 && e_grd[i] == 0)) begin
        errors++; $display("FAIL dir%0d_zero: got %b expected %b", i, zero, (e_sig[i] == 0 && e_grd[i] == 0));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] ts [10];
    logic [7:0]  td [10];
    logic [26:0] exp_r;
    bit          exp_v;
    for (int unsigned i = 0; i < 10; i++) begin
      ts[i] = 24'(32'h0F0F0F ^ (i * 32'h00135791));
      td[i] = 8'(i * 3);
    end
    @(negedge clk);
    for (int unsigned c = 0; c < 13; c++) begin
      if (c != 0) @(negedge clk);
      exp_v = (c >= 2 && c <= 11);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL b2b_valid_c%0d: got %b expected %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        exp_r = model_align(ts[c-2], td[c-2]);
        checks++;
        if ({sig_out, guard, tag_out} !== {exp_r, 4'(c-2)}) begin
          errors++;
          $display("FAIL b2b_data_c%0d: got %h expected %h", c, {sig_out, guard, tag_out}, {exp_r, 4'(c-2)});
        end
      end
      out_ready = 1'b1;
      if (c < 10) begin
        in_valid = 1'b1; sig_in = ts[c]; diff = td[c]; tag_in = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready_c%0d: got %b expected 1", c, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    // A: 0x800001>>24 -> 0,101  B: 0xC00001>>1 -> 0x600000,100  C: 0x123456>>8 -> 0x001234,011
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; sig_in = 24'h800001; diff = 8'd24; tag_in = 4'h1;
    #1; checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b expected 1", in_ready); end
    @(negedge clk);
    sig_in = 24'hC00001; diff = 8'd1; tag_in = 4'h2;
    #1; checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b expected 1", in_ready); end
    @(negedge clk);
    sig_in = 24'h123456; diff = 8'd8; tag_in = 4'h3;
    for (int unsigned k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_k%0d: in_ready got %b expected 0", k, in_ready); end
      checks++;
      if ({out_valid, sig_out, guard, tag_out} !== {1'b1, 24'h000000, 3'b101, 4'h1}) begin
        errors++;
        $display("FAIL bp_hold_k%0d: got %h expected %h", k, {out_valid, sig_out, guard, tag_out},
                 {1'b1, 24'h000000, 3'b101, 4'h1});
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1; checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, sig_out, guard, tag_out} !== {1'b1, 24'h600000, 3'b100, 4'h2}) begin
      errors++; $display("FAIL bp_out_b: got %h expected %h", {out_valid, sig_out, guard, tag_out},
                         {1'b1, 24'h600000, 3'b100, 4'h2});
    end
    @(negedge clk);
    checks++;
    if ({out_valid, sig_out, guard, tag_out} !== {1'b1, 24'h001234, 3'b011, 4'h3}) begin
      errors++; $display("FAIL bp_out_c: got %h expected %h", {out_valid, sig_out, guard, tag_out},
                         {1'b1, 24'h001234, 3'b011, 4'h3});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; sig_in = 24'hABCDEF; diff = 8'd4; tag_in = 4'h5;
    @(negedge clk);
    sig_in = 24'h123456; diff = 8'd9; tag_in = 4'h6;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sig_out, guard, tag_out} !== '0) begin
      errors++; $display("FAIL rst_async_clear: got %h expected 0", {out_valid, sig_out, guard, tag_out});
    end
    @(negedge clk);
    #1 rst = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_no_stale_k%0d: got v=%b rdy=%b expected v=0 rdy=1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [30:0] sb [$];
    logic [30:0] exp_e;
    int          sent = 0;
    int          cyc  = 0;
    while ((sent < 300 || sb.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (sent < 300 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        sig_in   = ($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom);
        diff     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
        tag_in   = 4'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rnd_spurious: unexpected result %h", {sig_out, guard, tag_out});
        end else begin
          exp_e = sb.pop_front();
          if ({sig_out, guard, tag_out} !== exp_e) begin
            errors++; $display("FAIL rnd_data: got %h expected %h", {sig_out, guard, tag_out}, exp_e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({model_align(sig_in, diff), tag_in});
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (sb.size() != 0 || sent < 300) begin
      errors++; $display("FAIL rnd_timeout: sent=%0d pending=%0d expected sent=300 pending=0", sent, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
